// File: rtl/fwd_sel_if.sv
// Operand-forwarding selector bundle: request, forwarding sources, and registered operand.
// FWD_SEL_STATS_EN adds the forward/stall counters to the bundle.
interface fwd_sel_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 3,
   parameter int AW    = 5
);
   localparam int SW = $clog2(NSRC + 1);

   logic                  en;
   logic                  flush;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rf_data;
   logic [NSRC-1:0]       src_valid;
   logic [NSRC-1:0]       src_ready;
   logic [NSRC*AW-1:0]    src_addr;
   logic [NSRC*WIDTH-1:0] src_data;
   logic                  hazard;
   logic [WIDTH-1:0]      out_data;
   logic [AW-1:0]         out_addr;
   logic                  out_valid;
   logic [SW-1:0]         out_src;
`ifdef FWD_SEL_STATS_EN
   logic [15:0]           fwd_cnt;
   logic [15:0]           stall_cnt;

   modport master (
      output en, flush, rd_addr, rf_data, src_valid, src_ready, src_addr, src_data,
      input  hazard, out_data, out_addr, out_valid, out_src, fwd_cnt, stall_cnt
   );
   modport slave (
      input  en, flush, rd_addr, rf_data, src_valid, src_ready, src_addr, src_data,
      output hazard, out_data, out_addr, out_valid, out_src, fwd_cnt, stall_cnt
   );
`else
   modport master (
      output en, flush, rd_addr, rf_data, src_valid, src_ready, src_addr, src_data,
      input  hazard, out_data, out_addr, out_valid, out_src
   );
   modport slave (
      input  en, flush, rd_addr, rf_data, src_valid, src_ready, src_addr, src_data,
      output hazard, out_data, out_addr, out_valid, out_src
   );
`endif
endinterface

// File: rtl/fwd_sel_reg.sv
// N-source operand forwarding selector with a stall/flush pipeline register.
// Optional FWD_SEL_STATS_EN adds saturating 16-bit fwd_cnt and stall_cnt counters.
module fwd_sel_reg #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 3,
   parameter int AW    = 5
) (
   input logic      clk,
   input logic      reset,
   fwd_sel_if.slave bus
);
   localparam int SW = $clog2(NSRC + 1);

   typedef enum logic {LOAD, STALL} mode_e;

   logic             selFound;
   logic             selReady;
   logic [WIDTH-1:0] selData;
   logic [SW-1:0]    selSrc;
   mode_e            mode_d;

   logic [WIDTH-1:0] outData_q;
   logic [AW-1:0]    outAddr_q;
   logic             outValid_q;
   logic [SW-1:0]    outSrc_q;

   // Scanning from oldest to youngest lets the youngest match overwrite older ones.
   always_comb begin
      selFound = 1'b0;
      selReady = 1'b1;
      selData  = (bus.rd_addr == '0) ? '0 : bus.rf_data;
      selSrc   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (bus.src_valid[i] && (bus.src_addr[i*AW +: AW] == bus.rd_addr) &&
             (bus.rd_addr != '0)) begin
            selFound = 1'b1;
            selReady = bus.src_ready[i];
            selData  = bus.src_data[i*WIDTH +: WIDTH];
            selSrc   = SW'(i + 1);
         end
      end
   end

   assign bus.hazard = selFound & ~selReady;

   // A flush always wins, so the register only stalls on an unflushed hazard.
   always_comb begin
      mode_d = (bus.hazard && !bus.flush) ? STALL : LOAD;
   end

   // Pipeline register: flush bubble, else hold on stall, else load when advancing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outData_q  <= '0;
         outAddr_q  <= '0;
         outValid_q <= 1'b0;
         outSrc_q   <= '0;
      end else if (bus.flush) begin
         outData_q  <= '0;
         outAddr_q  <= '0;
         outValid_q <= 1'b0;
         outSrc_q   <= '0;
      end else if (mode_d == LOAD && bus.en) begin
         outData_q  <= selData;
         outAddr_q  <= bus.rd_addr;
         outValid_q <= 1'b1;
         outSrc_q   <= selSrc;
      end
   end

   assign bus.out_data  = outData_q;
   assign bus.out_addr  = outAddr_q;
   assign bus.out_valid = outValid_q;
   assign bus.out_src   = outSrc_q;

`ifdef FWD_SEL_STATS_EN
   logic [15:0] fwdCnt_q;
   logic [15:0] stallCnt_q;

   // Counters saturate rather than wrap so long runs still read as "many".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwdCnt_q   <= '0;
         stallCnt_q <= '0;
      end else begin
         if (!bus.flush && mode_d == LOAD && bus.en && selSrc != '0 &&
             fwdCnt_q != 16'hFFFF) begin
            fwdCnt_q <= fwdCnt_q + 16'd1;
         end
         if (mode_d == STALL && stallCnt_q != 16'hFFFF) begin
            stallCnt_q <= stallCnt_q + 16'd1;
         end
      end
   end

   assign bus.fwd_cnt   = fwdCnt_q;
   assign bus.stall_cnt = stallCnt_q;
`endif
endmodule
